// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: LSB-first frames marked by ser_sync, optional
// trailing even-parity bit, delivered on a valid/ready register with overrun flag.
module shift_deser #(
  parameter int N         = 8,
  parameter int PARITY_EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ser_in,
  input  logic         ser_en,
  input  logic         ser_sync,
  output logic [N-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         par_err,
  output logic         overrun,
  output logic         busy
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_next_s;
  logic [CW-1:0]  cnt_r;
  logic [CW-1:0]  cnt_next_s;
  logic [N-1:0]   shift_r;
  logic [N-1:0]   shift_next_s;
  logic [N-1:0]   word_s;
  logic [N-1:0]   done_word_s;
  logic           last_bit_s;
  logic           complete_s;
  logic           par_err_s;

  // Returns 1 when data plus received parity bit has odd weight (even-parity violation).
  function automatic logic parity_mismatch(input logic [N-1:0] d, input logic p);
    return (^d) ^ p;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; a sync-qualified strobe always restarts the frame.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (ser_en && ser_sync) begin
          state_next_s = DATA;
        end else begin
          state_next_s = IDLE;
        end
      end
      DATA: begin
        if (ser_en && ser_sync) begin
          state_next_s = DATA;
        end else if (ser_en && last_bit_s) begin
          state_next_s = (PARITY_EN != 0) ? PAR : IDLE;
        end else begin
          state_next_s = DATA;
        end
      end
      PAR: begin
        if (ser_en && ser_sync) begin
          state_next_s = DATA;
        end else if (ser_en) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = PAR;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Buffer with the current strobe's bit merged in at the counter position.
  always_comb begin
    word_s         = shift_r;
    word_s[cnt_r]  = ser_in;
    last_bit_s     = (cnt_r == CW'(N - 1));
  end

  // Output/datapath logic: buffer and counter updates, frame completion.
  always_comb begin
    shift_next_s = shift_r;
    cnt_next_s   = cnt_r;
    complete_s   = 1'b0;
    par_err_s    = 1'b0;
    done_word_s  = word_s;
    busy         = (state_r != IDLE);
    if (ser_en && ser_sync) begin
      shift_next_s = {{(N-1){1'b0}}, ser_in};
      cnt_next_s   = CW'(1);
    end else if (ser_en) begin
      case (state_r)
        IDLE: begin
          cnt_next_s = cnt_r;
        end
        DATA: begin
          shift_next_s = word_s;
          if (last_bit_s) begin
            cnt_next_s = {CW{1'b0}};
            complete_s = (PARITY_EN == 0);
          end else begin
            cnt_next_s = cnt_r + CW'(1);
          end
        end
        PAR: begin
          complete_s  = 1'b1;
          done_word_s = shift_r;
          par_err_s   = parity_mismatch(shift_r, ser_in);
          cnt_next_s  = {CW{1'b0}};
        end
        default: begin
          cnt_next_s = {CW{1'b0}};
        end
      endcase
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Shift buffer and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= {N{1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else begin
      shift_r <= shift_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Output word register: a completion while the held word is unaccepted is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data  <= {N{1'b0}};
      m_valid <= 1'b0;
      par_err <= 1'b0;
      overrun <= 1'b0;
    end else if (complete_s) begin
      if (!m_valid || m_ready) begin
        m_data  <= done_word_s;
        par_err <= par_err_s;
        m_valid <= 1'b1;
        overrun <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
    end else begin
      overrun <= 1'b0;
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end else begin
        m_valid <= m_valid;
      end
    end
  end

endmodule

// File: tb/tb_shift_deser.sv
// Bench for shift_deser: two instances (with and without parity) share stimulus
// and are compared every cycle against a bit-list reference model.
module tb_shift_deser;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         ser_in;
  logic         ser_en;
  logic         ser_sync;
  logic         m_ready;
  logic [N-1:0] data1, data0;
  logic         valid1, valid0, perr1, perr0, ovr1, ovr0, busy1, busy0;

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 = no parity, 1 = parity.
  int       mlen   [2];
  bit       mbits  [2][N+1];
  bit [7:0] e_data [2];
  bit       e_valid[2];
  bit       e_perr [2];
  bit       e_ovr  [2];

  shift_deser #(.N(N), .PARITY_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_en(ser_en), .ser_sync(ser_sync),
    .m_data(data1), .m_valid(valid1), .m_ready(m_ready), .par_err(perr1),
    .overrun(ovr1), .busy(busy1)
  );

  shift_deser #(.N(N), .PARITY_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_en(ser_en), .ser_sync(ser_sync),
    .m_data(data0), .m_valid(valid0), .m_ready(m_ready), .par_err(perr0),
    .overrun(ovr0), .busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      mlen[k] = 0; e_data[k] = 8'h00; e_valid[k] = 1'b0; e_perr[k] = 1'b0; e_ovr[k] = 1'b0;
    end
  endfunction

  // One clock edge of receiver behaviour: collect bits since the last sync,
  // emit a word once N data bits (plus parity bit if enabled) are collected.
  function automatic void model_step(input int k);
    int  pe    = k;
    bit  comp  = 1'b0;
    int  word  = 0;
    int  ones  = 0;
    bit  hs    = e_valid[k] && m_ready;
    if (ser_en) begin
      if (ser_sync) begin
        mbits[k][0] = ser_in;
        mlen[k]     = 1;
      end else if (mlen[k] > 0) begin
        mbits[k][mlen[k]] = ser_in;
        mlen[k]++;
        if (mlen[k] == N + pe) begin
          comp = 1'b1;
          for (int i = 0; i < N; i++) word += int'(mbits[k][i]) * (1 << i);
          for (int i = 0; i < mlen[k]; i++) ones += int'(mbits[k][i]);
          mlen[k] = 0;
        end
      end
    end
    e_ovr[k] = 1'b0;
    if (comp) begin
      if (!e_valid[k] || m_ready) begin
        e_data[k]  = word[7:0];
        e_perr[k]  = (pe == 1) ? ((ones % 2) == 1) : 1'b0;
        e_valid[k] = 1'b1;
      end else begin
        e_ovr[k] = 1'b1;
      end
    end else if (hs) begin
      e_valid[k] = 1'b0;
    end
  endfunction

  function automatic void check_all();
    chk("data_p",  32'(data1),  32'(e_data[1]));
    chk("valid_p", 32'(valid1), 32'(e_valid[1]));
    chk("perr_p",  32'(perr1),  32'(e_perr[1]));
    chk("ovr_p",   32'(ovr1),   32'(e_ovr[1]));
    chk("busy_p",  32'(busy1),  32'(mlen[1] > 0));
    chk("data_n",  32'(data0),  32'(e_data[0]));
    chk("valid_n", 32'(valid0), 32'(e_valid[0]));
    chk("perr_n",  32'(perr0),  32'(e_perr[0]));
    chk("ovr_n",   32'(ovr0),   32'(e_ovr[0]));
    chk("busy_n",  32'(busy0),  32'(mlen[0] > 0));
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    ser_en = 1'b0; ser_sync = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ser_en = 1'b0; ser_sync = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] w, input int nbits, input int gap);
    for (int i = 0; i < nbits; i++) begin
      ser_en = 1'b1; ser_sync = (i == 0); ser_in = w[i];
      tick();
      if (gap > 0 && i < nbits - 1) idle(gap);
    end
    ser_en = 1'b0; ser_sync = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] w, input int gap, input bit with_par, input bit pbit);
    send_bits(w, N, gap);
    if (with_par) begin
      if (gap > 0) idle(gap);
      ser_en = 1'b1; ser_sync = 1'b0; ser_in = pbit;
      tick();
      ser_en = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; ser_in = 1'b0; ser_en = 1'b0; ser_sync = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    do_reset();
    chk("rst_valid", 32'(valid1), 32'd0);
    chk("rst_busy",  32'(busy1),  32'd0);
    idle(2);

    // Basic frame 0xA5 with correct parity.
    send_frame(8'hA5, 0, 1'b1, 1'b0);
    chk("basic_data",  32'(data1),  32'h0000_00A5);
    chk("basic_valid", 32'(valid1), 32'd1);
    chk("basic_perr",  32'(perr1),  32'd0);
    chk("basic_busy",  32'(busy1),  32'd0);
    idle(2);

    // Parity error, with gaps between bits.
    send_frame(8'h3C, 2, 1'b1, 1'b1);
    chk("perr_data", 32'(data1), 32'h0000_003C);
    chk("perr_flag", 32'(perr1), 32'd1);
    idle(1);

    // Backpressure and overrun.
    m_ready = 1'b0;
    send_frame(8'hA5, 0, 1'b1, 1'b0);
    send_frame(8'h3C, 0, 1'b1, 1'b0);
    chk("ovr_pulse", 32'(ovr1),  32'd1);
    chk("ovr_held",  32'(data1), 32'h0000_00A5);
    idle(1);
    chk("ovr_clear", 32'(ovr1), 32'd0);
    m_ready = 1'b1;
    idle(1);
    chk("hs_drop", 32'(valid1), 32'd0);
    idle(1);

    // Noise without sync, then a partial frame cut by a resync.
    ser_en = 1'b1; ser_sync = 1'b0;
    for (int i = 0; i < 3; i++) begin ser_in = 1'($urandom_range(0, 1)); tick(); end
    chk("noise_busy", 32'(busy1), 32'd0);
    send_bits(8'hFF, 4, 0);
    send_frame(8'h0F, 0, 1'b1, 1'b0);
    chk("resync_data", 32'(data1), 32'h0000_000F);
    idle(2);

    // Reset in the middle of a frame.
    send_bits(8'h55, 5, 0);
    do_reset();
    chk("midrst_busy", 32'(busy1), 32'd0);
    send_frame(8'hC3, 0, 1'b1, 1'b0);
    chk("midrst_data", 32'(data1), 32'h0000_00C3);
    idle(2);

    // Back-to-back frames on the no-parity instance.
    send_frame(8'h01, 0, 1'b0, 1'b0);
    chk("b2b_first", 32'(data0), 32'h0000_0001);
    send_frame(8'h80, 0, 1'b0, 1'b0);
    chk("b2b_second", 32'(data0), 32'h0000_0080);
    chk("b2b_novr",   32'(ovr0),  32'd0);
    idle(3);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        ser_en   = ($urandom_range(0, 3) != 0);
        ser_sync = ($urandom_range(0, 13) == 0);
        ser_in   = 1'($urandom_range(0, 1));
        m_ready  = ($urandom_range(0, 3) != 0);
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
